// File: rtl/wb4_sync_fifo_1_to_n_if.sv
// ---------------------------------------------------------------------------
// wb4_sync_fifo_1_to_n_if
// Bus bundle for the 1-to-N width up-converting Wishbone B4 pipelined FIFO.
//
// Write side (narrow units, master -> FIFO):
//   i_wb4_in_scyc, i_wb4_in_sstb, i_wb4_in_sdata    driven by the producer
//   o_wb4_in_sack, o_wb4_in_sstall                  driven by the FIFO
// Read side (wide packed words, FIFO -> consumer):
//   i_wb4_out_scyc, i_wb4_out_sstb                  driven by the consumer
//   o_wb4_out_sdata, o_wb4_out_sack,
//   o_wb4_out_sstall                                driven by the FIFO
//
// Modports: slave = the FIFO, master = the surrounding logic / bench.
// ---------------------------------------------------------------------------
interface wb4_sync_fifo_1_to_n_if #(
  parameter int P_DATA_MSB = 7,
  parameter int P_RATIO    = 4
);

  logic                                i_wb4_in_scyc;
  logic                                i_wb4_in_sstb;
  logic [P_DATA_MSB:0]                 i_wb4_in_sdata;
  logic                                o_wb4_in_sack;
  logic                                o_wb4_in_sstall;

  logic                                i_wb4_out_scyc;
  logic                                i_wb4_out_sstb;
  logic [(P_DATA_MSB+1)*P_RATIO-1:0]   o_wb4_out_sdata;
  logic                                o_wb4_out_sack;
  logic                                o_wb4_out_sstall;

  modport slave (
    input  i_wb4_in_scyc, i_wb4_in_sstb, i_wb4_in_sdata,
    output o_wb4_in_sack, o_wb4_in_sstall,
    input  i_wb4_out_scyc, i_wb4_out_sstb,
    output o_wb4_out_sdata, o_wb4_out_sack, o_wb4_out_sstall
  );

  modport master (
    output i_wb4_in_scyc, i_wb4_in_sstb, i_wb4_in_sdata,
    input  o_wb4_in_sack, o_wb4_in_sstall,
    output i_wb4_out_scyc, i_wb4_out_sstb,
    input  o_wb4_out_sdata, o_wb4_out_sack, o_wb4_out_sstall
  );

endinterface

// File: rtl/wb4_sync_fifo_1_to_n.sv
// ---------------------------------------------------------------------------
// wb4_sync_fifo_1_to_n
// Single-clock Wishbone B4 pipelined FIFO with width up-conversion. P_RATIO
// consecutive narrow write units are packed (first unit in the LSBs) into one
// wide word and stored; the read port returns whole packed words.
//
// Ports:
//   i_wb4_sclk   clock, rising edge
//   i_wb4_srst   asynchronous active-high reset
//   bus          wb4_sync_fifo_1_to_n_if.slave (write and read handshakes)
//   o_level      number of whole words stored (0..P_DEPTH)
//   o_afull      level >= P_AFULL
//   o_aempty     level <= P_AEMPTY
// ---------------------------------------------------------------------------
module wb4_sync_fifo_1_to_n #(
  parameter int P_DATA_MSB = 7,
  parameter int P_RATIO    = 4,
  parameter int P_DEPTH    = 64,
  parameter int P_AFULL    = 56,
  parameter int P_AEMPTY   = 8
) (
  input  logic                        i_wb4_sclk,
  input  logic                        i_wb4_srst,
  wb4_sync_fifo_1_to_n_if.slave       bus,
  output logic [$clog2(P_DEPTH):0]    o_level,
  output logic                        o_afull,
  output logic                        o_aempty
);

  localparam int UW = P_DATA_MSB + 1;
  localparam int WW = UW * P_RATIO;
  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = $clog2(P_RATIO);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] LAST_UNIT = CW'(P_RATIO - 1);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(P_DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(P_AFULL);
  localparam logic [LW-1:0] AEMPT_LVL = LW'(P_AEMPTY);

  logic [WW-1:0] mem [P_DEPTH];

  logic [CW-1:0] pack_cnt;
  logic [WW-1:0] pack_reg;
  logic [WW-1:0] next_word;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [WW-1:0] out_data;
  logic          in_ack;
  logic          out_ack;

  logic          full;
  logic          last_unit;
  logic          wr_acc;
  logic          word_done;
  logic          rd_acc;

  // Only the unit that would complete a word is held off while full; the
  // earlier units of the next word only go into the pack register.
  assign full      = (level == DEPTH_LVL);
  assign last_unit = (pack_cnt == LAST_UNIT);
  assign wr_acc    = bus.i_wb4_in_scyc & bus.i_wb4_in_sstb & ~bus.o_wb4_in_sstall;
  assign word_done = wr_acc & last_unit;
  assign rd_acc    = bus.i_wb4_out_scyc & bus.i_wb4_out_sstb & ~bus.o_wb4_out_sstall;

  assign bus.o_wb4_in_sstall  = full & last_unit;
  assign bus.o_wb4_out_sstall = (level == '0);
  assign bus.o_wb4_in_sack    = in_ack;
  assign bus.o_wb4_out_sack   = out_ack;
  assign bus.o_wb4_out_sdata  = out_data;

  assign o_level  = level;
  assign o_afull  = (level >= AFULL_LVL);
  assign o_aempty = (level <= AEMPT_LVL);

  // Pack register contents with the current unit merged into its slot; this
  // is both the next pack value and, on the last unit, the word to store.
  always_comb begin
    next_word = pack_reg;
    next_word[int'(pack_cnt) * UW +: UW] = bus.i_wb4_in_sdata;
  end

  // Storage array is not reset, so it lives in its own block.
  always_ff @(posedge i_wb4_sclk) begin
    if (word_done) begin
      mem[wr_ptr] <= next_word;
    end
  end

  // Packing, pointers, level and registered handshake outputs.
  always_ff @(posedge i_wb4_sclk or posedge i_wb4_srst) begin
    if (i_wb4_srst) begin
      pack_cnt <= '0;
      pack_reg <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      out_data <= '0;
      in_ack   <= 1'b0;
      out_ack  <= 1'b0;
    end else begin
      in_ack  <= wr_acc;
      out_ack <= rd_acc;

      if (wr_acc) begin
        if (last_unit) begin
          pack_cnt <= '0;
          pack_reg <= '0;
          wr_ptr   <= wr_ptr + 1'b1;
        end else begin
          pack_cnt <= pack_cnt + 1'b1;
          pack_reg <= next_word;
        end
      end

      if (rd_acc) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end

      case ({word_done, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: doc/wb4_sync_fifo_1_to_n.md
Name: wb4_sync_fifo_1_to_n

Overview:
- Single-clock Wishbone B4 (pipelined) FIFO with width up-conversion.
- Write port accepts narrow units; P_RATIO consecutive units are packed into one wide word, first unit in the LSBs, and stored.
- Read port returns whole packed words.
- Sits between narrow byte/stream producers and wide-bus consumers in the same clock domain. Also reports fill level and almost-full/almost-empty flags.

Parameters:
- P_DATA_MSB, 7, input unit width-1; output word width is (P_DATA_MSB+1)*P_RATIO.
- P_RATIO, 4, units per output word; integer >= 2.
- P_DEPTH, 64, storage depth in output words; power of 2, >= 2.
- P_AFULL, 56, o_afull asserts when level >= P_AFULL.
- P_AEMPTY, 8, o_aempty asserts when level <= P_AEMPTY.

Ports:
- i_wb4_sclk  in  1  clock, rising edge.
- i_wb4_srst  in  1  reset, asynchronous, active-high.
- i_wb4_in_scyc  in  1  write cycle.
- i_wb4_in_sstb  in  1  write strobe.
- i_wb4_in_sdata  in  P_DATA_MSB+1  write unit.
- o_wb4_in_sack  out  1  write ack.
- o_wb4_in_sstall  out  1  write stall.
- i_wb4_out_scyc  in  1  read cycle.
- i_wb4_out_sstb  in  1  read strobe.
- o_wb4_out_sdata  out  (P_DATA_MSB+1)*P_RATIO  read word.
- o_wb4_out_sack  out  1  read ack / data valid.
- o_wb4_out_sstall  out  1  read stall (empty).
- o_level  out  $clog2(P_DEPTH)+1  stored whole words.
- o_afull  out  1  almost full.
- o_aempty  out  1  almost empty.

Behaviour:
- Reset (async, active-high): acks=0, o_wb4_out_sdata=0, level=0, pointers=0, pack count=0, pack register=0.
  - During reset: o_wb4_out_sstall=1, o_aempty=1, o_afull=0, o_wb4_in_sstall=0.
  - Memory array is not reset.
  - A partial pack in progress is discarded.
- Write accept: scyc & sstb & ~o_wb4_in_sstall.
  - Unit k (k = pack count, 0..P_RATIO-1) goes to bits [k*(P_DATA_MSB+1) +: P_DATA_MSB+1].
  - Pack count increments, wrapping from P_RATIO-1 to 0.
  - On the accept with k=P_RATIO-1, the completed word (register contents plus current unit) is written to memory at wr_ptr; wr_ptr and level update on that edge.
- o_wb4_in_sstall = full & (pack count == P_RATIO-1). Units 0..P_RATIO-2 are always accepted while full. Full = (level == P_DEPTH), registered. A same-cycle read does not clear stall (no fall-through).
- o_wb4_in_sack: registered. Next cycle = write accept; forced 0 on next edge if scyc=0.
- Read accept: scyc & sstb & ~o_wb4_out_sstall, where o_wb4_out_sstall = (level == 0).
  - On accept, the memory word at rd_ptr is registered into o_wb4_out_sdata; rd_ptr increments.
  - o_wb4_out_sack=1 on the following cycle, with data valid in that same cycle.
  - Latency: strobe to ack = 1 cycle. Back-to-back reads give one ack per cycle.
  - o_wb4_out_sdata holds its value when no read is accepted.
- Pointers: $clog2(P_DEPTH) bits, natural wrap P_DEPTH-1 -> 0.
- Level update per edge:
  - +1 on word completion only.
  - -1 on read accept only.
  - Unchanged when both occur in the same cycle.
- A word completed in cycle t is readable from cycle t+1; stall drops at t+1.
- o_afull and o_aempty are combinational from registered level.
- scyc low: no accepts, ack cleared next edge. Pack count and partial data are retained (cycle drop does not abort a partial word).
- Overflow and underflow are impossible by construction. The bench asserts level never exceeds P_DEPTH and never wraps below 0.

Test Plan:
- Test config: P_DATA_MSB=7, P_RATIO=4, P_DEPTH=4, P_AFULL=3, P_AEMPTY=1.
- Write 0x11,0x22,0x33,0x44 back-to-back -> 4 in-acks each one cycle after its strobe; o_level=1 on the cycle after the 4th accept. Then read -> out-ack 1 cycle later with o_wb4_out_sdata=0x44332211, level 0, out-stall=1.
- Continuous write of 20 units with no reads -> level reaches 4, o_afull=1 from level 3; units 17-19 accepted; 20th unit sees o_wb4_in_sstall=1 and gets no ack. One read -> stall drops next cycle and the 20th unit is accepted, level returns to 4.
- Read strobe with level 0 -> o_wb4_out_sstall=1, no ack, rd_ptr unchanged, o_aempty=1.
- With level=2, 4th unit of a word accepted in the same cycle as a read -> level stays 2; read data is the oldest word; the new word is returned after the next read.
- Assert i_wb4_srst asynchronously (mid-clock) after 2 units packed and level=3 -> outputs go to reset values without waiting for an edge. After release, writing 0xA0..0xA3 yields word 0xA3A2A1A0 (old partial discarded).
- Drop i_wb4_in_scyc with sstb=1 after 2 units, hold 3 cycles, resume with 0x77,0x88 -> no acks while cyc=0; stored word = {0x88,0x77,unit1,unit0}.
